reg_fifo_24b: RTL and testbench

Register-based byte FIFO that converts width: it accepts 64-bit words (8 bytes) and emits 24-bit words (3 bytes, e.g. one RGB pixel). It sits in the input layer, between a 64-bit memory/stream read path and a 24-bit pixel consumer. Occupancy is reported in bytes. Storage is flip-flops only, with no RAM macro.

---
 rtl/reg_fifo_24b_pkg.sv | 13 +
 rtl/reg_fifo_24b.sv | 89 ++++++++
 tb/tb_reg_fifo_24b.sv | 117 +++++++++++
 3 files changed

// File: rtl/reg_fifo_24b_pkg.sv
// reg_fifo_24b_pkg
//   Shared sizing constants and the byte type for the 64-bit to 24-bit
//   register FIFO.
package reg_fifo_24b_pkg;

  localparam int IN_BYTES    = 8;   // bytes accepted per push
  localparam int OUT_BYTES   = 3;   // bytes returned per pop
  localparam int DEPTH_BYTES = 15;  // byte capacity
  localparam int COUNT_W     = 4;   // occupancy width, holds DEPTH_BYTES

  typedef logic [7:0] byte_t;

endpackage : reg_fifo_24b_pkg

// File: rtl/reg_fifo_24b.sv
// reg_fifo_24b
//   Flip-flop byte FIFO that converts width: 64-bit words in, 24-bit words
//   out. The queue is a shift-down byte array with the oldest byte in slot 0.
//   Slots at and above count are always zero. That lets a push be merged
//   with a plain OR of the shifted-in word.
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous reset, active HIGH (asserted while 1)
//   data_in  in   push word, byte 0 (bits [7:0]) is enqueued first
//   push     in   enqueue request
//   pop      in   dequeue request
//   data_o   out  last dequeued word, oldest byte in bits [7:0]
//   count    out  number of valid bytes stored
module reg_fifo_24b
  import reg_fifo_24b_pkg::*;
#(
  parameter int P_IN_BYTES    = IN_BYTES,
  parameter int P_OUT_BYTES   = OUT_BYTES,
  parameter int P_DEPTH_BYTES = DEPTH_BYTES,
  parameter int P_COUNT_W     = COUNT_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [8*P_IN_BYTES-1:0]  data_in,
  input  logic                     push,
  input  logic                     pop,
  output logic [8*P_OUT_BYTES-1:0] data_o,
  output logic [P_COUNT_W-1:0]     count
);

  // Sized copies of the byte constants. The occupancy math runs one bit
  // wider than count so that count + IN_BYTES cannot wrap.
  localparam logic [P_COUNT_W:0] LP_IN    = (P_COUNT_W+1)'(P_IN_BYTES);
  localparam logic [P_COUNT_W:0] LP_OUT   = (P_COUNT_W+1)'(P_OUT_BYTES);
  localparam logic [P_COUNT_W:0] LP_DEPTH = (P_COUNT_W+1)'(P_DEPTH_BYTES);

  byte_t [P_DEPTH_BYTES-1:0]  r_mem;
  logic  [P_COUNT_W-1:0]      r_count;
  logic  [8*P_OUT_BYTES-1:0]  r_data_o;

  logic                       w_pop_ok;
  logic                       w_push_ok;
  logic  [P_COUNT_W:0]        w_cnt_ext;
  logic  [P_COUNT_W:0]        w_after_pop;
  logic  [P_COUNT_W:0]        w_count_nxt;
  byte_t [P_DEPTH_BYTES-1:0]  w_kept;
  byte_t [P_DEPTH_BYTES-1:0]  w_in_ext;
  byte_t [P_DEPTH_BYTES-1:0]  w_mem_nxt;

  // Accept logic. The pop is judged on the pre-edge occupancy. The push is
  // judged on the occupancy left after that pop.
  always_comb begin
    w_cnt_ext   = {1'b0, r_count};
    w_pop_ok    = pop && (w_cnt_ext >= LP_OUT);
    w_after_pop = w_pop_ok ? (w_cnt_ext - LP_OUT) : w_cnt_ext;
    w_push_ok   = push && ((w_after_pop + LP_IN) <= LP_DEPTH);
    w_count_nxt = w_after_pop + (w_push_ok ? LP_IN : '0);
  end

  // Next storage image. The survivors slide down by one output word, and
  // the pushed bytes land directly behind them. The zero-above-count
  // invariant makes the OR merge exact.
  always_comb begin
    w_kept   = w_pop_ok ? (r_mem >> (8*P_OUT_BYTES)) : r_mem;
    w_in_ext = '0;
    w_in_ext[P_IN_BYTES-1:0] = data_in;
    w_mem_nxt = w_kept;
    if (w_push_ok)
      w_mem_nxt = w_kept | (w_in_ext << {w_after_pop, 3'b000});
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_mem    <= '0;
      r_count  <= '0;
      r_data_o <= '0;
    end else begin
      r_mem   <= w_mem_nxt;
      r_count <= w_count_nxt[P_COUNT_W-1:0];
      if (w_pop_ok)
        r_data_o <= r_mem[P_OUT_BYTES-1:0];
    end
  end

  assign data_o = r_data_o;
  assign count  = r_count;

endmodule : reg_fifo_24b

// File: tb/tb_reg_fifo_24b.sv
module tb_reg_fifo_24b;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] data_in;
  logic        push;
  logic        pop;
  logic [23:0] data_o;
  logic [3:0]  count;

  int checks   = 0;
  int failures = 0;

  reg_fifo_24b dut (
    .clk    (clk),
    .reset_n(reset_n),
    .data_in(data_in),
    .push   (push),
    .pop    (pop),
    .data_o (data_o),
    .count  (count)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] W_A = 64'h2343253267384758;
  localparam logic [63:0] W_B = 64'h4567485739576944;
  localparam logic [63:0] W_1 = 64'h0807060504030201;
  localparam logic [63:0] W_2 = 64'h100F0E0D0C0B0A09;
  localparam logic [63:0] W_3 = 64'h1817161514131211;

  task automatic chk(input string tag, input logic [3:0] exp_cnt, input logic [23:0] exp_do);
    checks++;
    assert (count === exp_cnt) else begin
      failures++;
      $error("FAIL %s count obs=%0d exp=%0d", tag, count, exp_cnt);
    end
    checks++;
    assert (data_o === exp_do) else begin
      failures++;
      $error("FAIL %s data_o obs=%h exp=%h", tag, data_o, exp_do);
    end
  endtask

  // One clock with the given requests. Inputs change 1ns after the edge,
  // so they are sampled on the next edge. Outputs are checked after it.
  task automatic step(input logic p, input logic q, input logic [63:0] d);
    push = p; pop = q; data_in = d;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1; push = 1'b0; pop = 1'b0; data_in = W_A;
    #1;
    // Reset held with requests toggling
    for (int i = 0; i < 4; i++) begin
      step(i[0], ~i[0], W_A);
      chk("rst_hold", 4'd0, 24'h0);
    end
    reset_n = 1'b0;
    step(1'b0, 1'b0, W_A);
    chk("rst_release", 4'd0, 24'h0);
    step(1'b0, 1'b0, W_A);
    chk("idle", 4'd0, 24'h0);

    // Basic push and pop
    step(1'b1, 1'b0, W_A);      chk("push_a", 4'd8, 24'h0);
    step(1'b0, 1'b1, 64'h0);    chk("pop1", 4'd5, 24'h384758);
    step(1'b0, 1'b1, 64'h0);    chk("pop2", 4'd2, 24'h253267);
    step(1'b0, 1'b1, 64'h0);    chk("pop_under", 4'd2, 24'h253267);
    step(1'b0, 1'b1, 64'h0);    chk("pop_under2", 4'd2, 24'h253267);

    // Push and pop together at count 2: the pop is ignored
    step(1'b1, 1'b1, W_B);      chk("pushpop_c2", 4'd10, 24'h253267);
    step(1'b0, 1'b1, 64'h0);    chk("pop_span", 4'd7, 24'h442343);
    step(1'b0, 1'b1, 64'h0);    chk("pop_b1", 4'd4, 24'h395769);
    step(1'b0, 1'b1, 64'h0);    chk("pop_b2", 4'd1, 24'h674857);

    // Overflow cases starting from count 8
    reset_n = 1'b1; #1; reset_n = 1'b0;
    chk("rst_pulse", 4'd0, 24'h0);
    step(1'b1, 1'b0, W_1);      chk("push_1", 4'd8, 24'h0);
    step(1'b1, 1'b0, W_2);      chk("ovf_push8", 4'd8, 24'h0);
    step(1'b1, 1'b1, W_2);      chk("pushpop_c8", 4'd13, 24'h030201);
    step(1'b1, 1'b0, W_3);      chk("ovf_push13", 4'd13, 24'h030201);

    // Fill to exactly 15, then drain in FIFO order
    step(1'b0, 1'b1, 64'h0);    chk("pop_c10", 4'd10, 24'h060504);
    step(1'b0, 1'b1, 64'h0);    chk("pop_c7", 4'd7, 24'h090807);
    step(1'b1, 1'b0, W_3);      chk("fill15", 4'd15, 24'h090807);
    step(1'b0, 1'b1, 64'h0);    chk("drain1", 4'd12, 24'h0C0B0A);
    step(1'b0, 1'b1, 64'h0);    chk("drain2", 4'd9, 24'h0F0E0D);
    step(1'b0, 1'b1, 64'h0);    chk("drain3", 4'd6, 24'h121110);
    step(1'b0, 1'b1, 64'h0);    chk("drain4", 4'd3, 24'h151413);
    step(1'b0, 1'b1, 64'h0);    chk("drain5", 4'd0, 24'h181716);
    step(1'b0, 1'b1, 64'h0);    chk("drain_empty", 4'd0, 24'h181716);

    // Asynchronous reset mid-stream at count 10
    step(1'b1, 1'b0, W_1);      chk("ms_push", 4'd8, 24'h181716);
    step(1'b0, 1'b1, 64'h0);    chk("ms_pop", 4'd5, 24'h030201);
    step(1'b1, 1'b0, W_2);      chk("ms_push2", 4'd13, 24'h030201);
    step(1'b0, 1'b1, 64'h0);    chk("ms_pop2", 4'd10, 24'h060504);
    #2 reset_n = 1'b1;
    #1 chk("async_rst", 4'd0, 24'h0);
    @(negedge clk);
    reset_n = 1'b0;
    step(1'b0, 1'b0, 64'h0);    chk("post_rst", 4'd0, 24'h0);
    step(1'b1, 1'b0, W_3);      chk("post_push", 4'd8, 24'h0);
    step(1'b0, 1'b1, 64'h0);    chk("post_pop", 4'd5, 24'h131211);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reg_fifo_24b
